// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: two-master (icache = m0, dcache = m1) to one-slave AXI4
// read arbiter. One burst in flight at a time. Round-robin on contention,
// registered AR channel towards the slave, combinational R routing back to
// the granted master.
//
// Handshake semantics: a transfer happens on a channel in exactly the cycle
// where its valid and ready are both high. A master holds arvalid with a
// stable payload until it sees arready. The slave holds s_arvalid with a
// stable payload until s_arready. R beats move only on s_rvalid & s_rready,
// so a master deasserting rready stalls the slave without losing a beat.
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // master 0 (instruction cache)
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    // master 1 (data cache)
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    // slave AR channel
    output logic [3:0]        s_arid,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [7:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    output logic [1:0]        s_arlock,
    output logic [3:0]        s_arcache,
    output logic [2:0]        s_arprot,
    output logic              s_arvalid,
    input  logic              s_arready,
    // slave R channel
    input  logic [3:0]        s_rid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    input  logic              s_rvalid,
    output logic              s_rready,
    // FSM state for observation: 0 IDLE, 1 ADDR, 2 DATA
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;

    logic req_any;
    logic sel;
    logic r_xfer;

    // Routing uses the registered grant, so the returned ID is not needed.
    logic s_rid_unused;
    assign s_rid_unused = ^s_rid;

    // Only one master requesting wins outright; on contention the master
    // that did not win last time goes first.
    assign req_any = m0_arvalid | m1_arvalid;
    assign sel     = (m0_arvalid & m1_arvalid) ? ~last_grant_q : m1_arvalid;
    assign r_xfer  = s_rvalid & s_rready;

    // State register and latched request payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
        end
    end

    // Next-state and payload capture.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d      = ST_ADDR;
                    grant_d      = sel;
                    last_grant_d = sel;
                    addr_d       = sel ? m1_araddr : m0_araddr;
                    len_d        = sel ? m1_arlen  : m0_arlen;
                    size_d       = sel ? m1_arsize : m0_arsize;
                end
            end
            ST_ADDR: begin
                if (s_arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_xfer && s_rlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-state handshake outputs; payload fields are always routed.
    always_comb begin
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                m0_arready = req_any & ~sel;
                m1_arready = req_any & sel;
            end
            ST_ADDR: begin
                s_arvalid = 1'b1;
            end
            ST_DATA: begin
                s_rready  = grant_q ? m1_rready : m0_rready;
                m0_rvalid = s_rvalid & ~grant_q;
                m1_rvalid = s_rvalid & grant_q;
            end
            default: begin
            end
        endcase
    end

    assign m0_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m0_rlast  = s_rlast;
    assign m1_rdata  = s_rdata;
    assign m1_rresp  = s_rresp;
    assign m1_rlast  = s_rlast;

    assign s_arid    = {3'b000, grant_q};
    assign s_araddr  = addr_q;
    assign s_arlen   = len_q;
    assign s_arsize  = size_q;
    assign s_arburst = 2'b01;
    assign s_arlock  = 2'b00;
    assign s_arcache = 4'b0000;
    assign s_arprot  = 3'b000;

    assign dbg_state = state_q;

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-master to one-slave AXI4 read-channel arbiter between the instruction cache (master 0), the data cache (master 1) and the single AXI read port of the SoC bus. Each cache issues one burst refill at a time on a simplified AR/R interface. The arbiter grants one master per transaction (round-robin on contention), drives the full AXI AR channel, and routes the R beats back to the granted master until `rlast`. Write channels are out of scope and are handled by a separate block.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `m0_araddr` / `m1_araddr` input ADDR_W: burst start address.
- `m0_arlen` / `m1_arlen` input 8: beats minus one.
- `m0_arsize` / `m1_arsize` input 3: beat size.
- `m0_arvalid` / `m1_arvalid` input 1: request valid. Held with stable payload until `arready`.
- `m0_arready` / `m1_arready` output 1: request accepted (one-cycle pulse).
- `m0_rdata` / `m1_rdata` output DATA_W: returned beat data.
- `m0_rresp` / `m1_rresp` output 2: returned beat response.
- `m0_rlast` / `m1_rlast` output 1: last beat of the burst.
- `m0_rvalid` / `m1_rvalid` output 1: beat valid.
- `m0_rready` / `m1_rready` input 1: master accepts the beat.
- `s_arid` output 4: `{3'b0, grant}`.
- `s_araddr` output ADDR_W: registered address.
- `s_arlen` output 8: registered burst length.
- `s_arsize` output 3: registered beat size.
- `s_arburst` output 2: constant 2'b01 (INCR).
- `s_arlock` output 2: constant 0.
- `s_arcache` output 4: constant 0.
- `s_arprot` output 3: constant 0.
- `s_arvalid` output 1: slave address valid.
- `s_arready` input 1: slave address accepted.
- `s_rid` input 4: ignored; routing uses `grant`.
- `s_rdata` input DATA_W: beat data.
- `s_rresp` input 2: beat response.
- `s_rlast` input 1: last beat.
- `s_rvalid` input 1: beat valid.
- `s_rready` output 1: forwarded from the granted master's `rready`.

## Operation
- **Registers:**
  - `state`: IDLE, ADDR or DATA.
  - `grant` (1 bit).
  - `last_grant` (1 bit).
  - Latched `addr` / `len` / `size`.
- **IDLE:**
  - If only one `mX_arvalid` is high, select that master.
  - If both are high, select `~last_grant`.
  - In the same cycle:
    - `mX_arready` = 1 for the selected master only (combinational).
    - Latch `grant`.
    - Latch that master's `araddr` / `arlen` / `arsize`.
    - Set `last_grant <= selected`.
    - Go to ADDR.
  - With no request, stay in IDLE.
- **ADDR:**
  - `s_arvalid` = 1 with the latched payload.
  - On `s_arready` go to DATA.
  - New `mX_arvalid` are not acknowledged.
- **DATA:**
  - `m[grant]_r{data,resp,last}` = `s_r{data,resp,last}`.
  - `m[grant]_rvalid` = `s_rvalid`.
  - `s_rready` = `m[grant]_rready`.
  - The non-granted master sees `rvalid` = 0; its `rdata` / `rresp` / `rlast` are don't-care.
  - A beat transfers when `s_rvalid & s_rready`.
  - On a transfer with `s_rlast`, go to IDLE.
- `s_rresp` errors are forwarded unchanged; the arbiter takes no other action on them.
- **Outputs outside their state:**
  - `s_arvalid` is 0 outside ADDR.
  - `s_rready` and `mX_rvalid` are 0 outside DATA.
  - `mX_arready` is 0 outside IDLE.

## Timing
- **Reset values:**
  - `state` = IDLE, `grant` = 0, `last_grant` = 1 (master 0 wins the first contention).
  - `s_arvalid` = 0, `s_rready` = 0.
  - All `mX_arready` = 0 and all `mX_rvalid` = 0.
  - `s_araddr` / `s_arlen` / `s_arsize` = 0.
- **Latency:** request accepted in cycle T; `s_arvalid` rises in T+1. This adds one cycle over a direct connection. R path is combinational, zero added latency.
- **Back-to-back:** if the last beat transfers in cycle T, the arbiter is in IDLE in T+1 and can accept the next request (`mX_arready`) in T+1.
- **Simultaneous requests:** strict alternation. With both masters continuously requesting, grants go 0,1,0,1...
- **A master dropping `arvalid` before grant** is a protocol violation by that master. The arbiter only samples `arvalid` in IDLE.
- **`arlen` = 0:** a single beat with `rlast` = 1 returns to IDLE after one transfer.
- **Stalls:** `s_arready` low holds ADDR with the payload stable. `m[grant]_rready` low stalls the slave; no beat is dropped or duplicated.
- **Reset mid-burst:** next cycle IDLE, all valids and readies 0, the pending burst is abandoned. Slave and masters are reset in the same cycle by system convention.

## Test plan
- **Single m0 request** (`araddr`=0x1fc00000, `arlen`=7, `arsize`=2), slave answers 8 beats 0x0..0x7 with `rlast` on the 8th:
  - `m0_arready` pulses for exactly one cycle.
  - `s_araddr`=0x1fc00000, `s_arid`=0, `s_arburst`=01.
  - `m0` receives 8 beats in order, `m1_rvalid` stays 0.
  - IDLE the cycle after the last beat.
- **Both masters request in the same cycle after reset:**
  - m0 granted first, `s_arid`=0.
  - After its `rlast`, m1 granted with `s_arid`=1.
  - A third simultaneous pair → m0.
- **`s_arready` held low 5 cycles:**
  - `s_arvalid` stays 1 with a constant payload.
  - No `mX_arready` during the wait.
  - DATA entered only after `s_arready`=1.
- **`m1_rready` toggled 1,0,0,1 during an 8-beat burst with `s_rvalid` constant:**
  - `s_rready` mirrors `m1_rready`.
  - m1 collects exactly 8 beats with correct data.
  - `s_rresp`=2'b10 on beat 3 appears on `m1_rresp`.
- **`arlen`=0 burst, then an immediate new m0 request:**
  - One beat transferred.
  - `m0_arready` asserted in the cycle after `rlast`.
- **`rst` asserted on beat 4 of 8:**
  - Next cycle `s_rready`=0, `s_arvalid`=0, all `mX_rvalid`=0.
  - A fresh m1 request after reset is granted normally.
